// File: rtl/board_io_pkg.sv
// Shared board I/O types: width of a key index and the event record
// carried from the debouncer to its consumer.
package board_io_pkg;
  localparam int KEY_CODE_W = 4;

  typedef struct packed {
    logic [KEY_CODE_W-1:0] code;
    logic                  press;
  } key_event_t;
endpackage

// File: rtl/ev_fifo.sv
// Small event queue: push/full on the write side, valid/ready on the read side.
// Read data reads as zero while the queue is empty.
module ev_fifo
  import board_io_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  key_event_t data_i,
  output logic       full_o,
  output logic       valid_o,
  input  logic       ready_i,
  output key_event_t data_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  key_event_t    mem_q [DEPTH];
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = valid_o && ready_i;
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = nextPtr(wr_q);
    if (do_pop)  rd_d = nextPtr(rd_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/key_debounce.sv
// Key debouncer: synchronizes raw keys, accepts a level change after it has been
// seen on STABLE_CNT consecutive sample ticks, and queues press/release events.
module key_debounce
  import board_io_pkg::*;
#(
  parameter int KEY_NUM    = 16,
  parameter int SAMPLE_DIV = 100,
  parameter int STABLE_CNT = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_NUM-1:0]    key_in,
  output logic [KEY_NUM-1:0]    key_state,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [KEY_CODE_W-1:0] ev_code,
  output logic                  ev_press,
  output logic                  ev_overflow
);
  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

  logic [KEY_NUM-1:0] sync1_q, sync2_q;
  logic [PW-1:0]      div_q, div_d;
  logic [SW-1:0]      stab_q [KEY_NUM];
  logic [SW-1:0]      stab_d [KEY_NUM];
  logic [KEY_NUM-1:0] state_q, state_d, pend_q, pend_d;
  logic [KEY_NUM-1:0] toggle, lowest, pushed;
  logic               ovf_q, ovf_d, tick, push, fifo_full;
  key_event_t         push_ev, pop_ev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
      state_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < KEY_NUM; k++) stab_q[k] <= '0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      div_q   <= div_d;
      stab_q  <= stab_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  // Any tick on which the synced level agrees with key_state restarts the count.
  always_comb begin
    tick   = (div_q == PW'(SAMPLE_DIV - 1));
    div_d  = tick ? '0 : div_q + PW'(1);
    stab_d = stab_q;
    toggle = '0;
    if (tick) begin
      for (int k = 0; k < KEY_NUM; k++) begin
        if (sync2_q[k] != state_q[k]) begin
          if (stab_q[k] == SW'(STABLE_CNT - 1)) begin
            toggle[k] = 1'b1;
            stab_d[k] = '0;
          end else begin
            stab_d[k] = stab_q[k] + SW'(1);
          end
        end else begin
          stab_d[k] = '0;
        end
      end
    end
    state_d = state_q ^ toggle;
  end

  // A second change before the first was queued cancels both and marks the loss.
  always_comb begin
    lowest  = pend_q & (~pend_q + KEY_NUM'(1));
    push_ev = '0;
    for (int k = 0; k < KEY_NUM; k++) begin
      if (lowest[k]) push_ev.code = KEY_CODE_W'(k);
    end
    push_ev.press = |(lowest & state_q);
    push   = (pend_q != '0) && (!fifo_full || (ev_valid && ev_ready));
    pushed = push ? lowest : '0;
    pend_d = (pend_q & ~pushed) ^ toggle;
    ovf_d  = ovf_q | (|(pend_q & ~pushed & toggle));
  end

  ev_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_ev),
    .full_o  (fifo_full),
    .valid_o (ev_valid),
    .ready_i (ev_ready),
    .data_o  (pop_ev)
  );

  assign key_state   = state_q;
  assign ev_overflow = ovf_q;
  assign ev_code     = pop_ev.code;
  assign ev_press    = pop_ev.press;
endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with a short prescaler (SAMPLE_DIV=4, STABLE_CNT=3).
// Edges are counted from the first rising edge with rst released.
module tb_key_debounce;
  localparam int SD = 4;
  localparam int SC = 3;
  localparam logic [15:0] MASK_D = 16'h84D1;
  localparam logic [15:0] MASK_E = 16'h00D1;
  localparam logic [15:0] MASK_F = 16'h19D1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] key_in = '0;
  logic        ev_ready = 1'b0;
  logic [15:0] key_state;
  logic        ev_valid;
  logic [3:0]  ev_code;
  logic        ev_press;
  logic        ev_overflow;

  int assertCnt = 0;
  int failCnt   = 0;
  int edgeCnt   = 0;
  int atEdge;
  int expCodes[$];

  always #5 clk = ~clk;

  key_debounce #(
    .KEY_NUM    (16),
    .SAMPLE_DIV (SD),
    .STABLE_CNT (SC),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_state   (key_state),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_code     (ev_code),
    .ev_press    (ev_press),
    .ev_overflow (ev_overflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCnt++;
    assert (observed === expected) else begin
      failCnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input logic ready);
    key_in   = keys;
    ev_ready = ready;
  endtask

  task automatic stepCycle(input int n);
    repeat (n) begin
      @(posedge clk);
      edgeCnt++;
      #1;
    end
  endtask

  // Edge on which a change applied just after edge e is accepted.
  function automatic int expToggle(input int e);
    int n = e + 3;
    while (n % SD != 0) n++;
    return n + (SC - 1) * SD;
  endfunction

  task automatic waitKeyBit(input int idx, input logic val, input int bound, output int seen);
    seen = -1;
    for (int i = 0; i < bound; i++) begin
      if (key_state[idx] === val) begin
        seen = edgeCnt;
        break;
      end
      stepCycle(1);
    end
    if (seen < 0) checkOutput("key_state wait timeout", 32'(key_state[idx]), 32'(val));
  endtask

  task automatic waitValid(input int bound);
    for (int i = 0; i < bound && ev_valid !== 1'b1; i++) stepCycle(1);
    if (ev_valid !== 1'b1) checkOutput("ev_valid wait timeout", 32'(ev_valid), 32'd1);
  endtask

  task automatic drainAndCheck(input string tag, input logic expPress, input int bound);
    int code;
    int cycles;
    cycles   = 0;
    ev_ready = 1'b1;
    while (expCodes.size() > 0 && cycles < bound) begin
      if (ev_valid === 1'b1) begin
        code = expCodes.pop_front();
        checkOutput({tag, " code"}, 32'(ev_code), 32'(code));
        checkOutput({tag, " press"}, 32'(ev_press), 32'(expPress));
      end
      stepCycle(1);
      cycles++;
    end
    checkOutput({tag, " all delivered"}, 32'(expCodes.size()), 32'd0);
    expCodes.delete();
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    checkOutput("reset key_state", 32'(key_state), 32'd0);
    checkOutput("reset ev_valid", 32'(ev_valid), 32'd0);
    checkOutput("reset ev_code", 32'(ev_code), 32'd0);
    checkOutput("reset ev_press", 32'(ev_press), 32'd0);
    checkOutput("reset ev_overflow", 32'(ev_overflow), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    edgeCnt = 0;

    $display("[TB] single press on key 5");
    stepCycle(2);
    applyStimulus(16'h0020, 1'b0);
    waitKeyBit(5, 1'b1, 40, atEdge);
    checkOutput("key5 accept edge", 32'(atEdge), 32'(expToggle(2)));
    checkOutput("key5 valid lags state", 32'(ev_valid), 32'd0);
    stepCycle(1);
    checkOutput("key5 valid", 32'(ev_valid), 32'd1);
    checkOutput("key5 code", 32'(ev_code), 32'd5);
    checkOutput("key5 press", 32'(ev_press), 32'd1);
    stepCycle(3);
    checkOutput("key5 held code", 32'(ev_code), 32'd5);
    checkOutput("key5 held valid", 32'(ev_valid), 32'd1);
    expCodes = '{5};
    drainAndCheck("key5 pop", 1'b1, 10);
    checkOutput("key5 queue empty", 32'(ev_valid), 32'd0);
    applyStimulus(16'h0000, 1'b1);
    expCodes = '{5};
    drainAndCheck("key5 release", 1'b0, 60);
    checkOutput("key5 released state", 32'(key_state), 32'd0);

    $display("[TB] glitch on key 2");
    applyStimulus(16'h0004, 1'b1);
    stepCycle(6);
    applyStimulus(16'h0000, 1'b1);
    stepCycle(30);
    checkOutput("glitch key_state", 32'(key_state), 32'd0);
    checkOutput("glitch no event", 32'(ev_valid), 32'd0);

    $display("[TB] keys 1 and 9 together");
    applyStimulus(16'h0202, 1'b1);
    waitValid(40);
    checkOutput("pair first code", 32'(ev_code), 32'd1);
    checkOutput("pair first press", 32'(ev_press), 32'd1);
    stepCycle(1);
    checkOutput("pair second valid", 32'(ev_valid), 32'd1);
    checkOutput("pair second code", 32'(ev_code), 32'd9);
    stepCycle(1);
    checkOutput("pair drained", 32'(ev_valid), 32'd0);
    applyStimulus(16'h0000, 1'b1);
    expCodes = '{1, 9};
    drainAndCheck("pair release", 1'b0, 60);

    $display("[TB] six keys under backpressure");
    applyStimulus(MASK_D, 1'b0);
    stepCycle(30);
    checkOutput("six key_state", 32'(key_state), 32'(MASK_D));
    checkOutput("six valid", 32'(ev_valid), 32'd1);
    checkOutput("six head code", 32'(ev_code), 32'd0);
    expCodes = '{0, 4, 6, 7, 10, 15};
    drainAndCheck("six press", 1'b1, 20);
    checkOutput("six overflow", 32'(ev_overflow), 32'd0);
    checkOutput("six drained", 32'(ev_valid), 32'd0);
    applyStimulus(16'h0000, 1'b1);
    expCodes = '{0, 4, 6, 7, 10, 15};
    drainAndCheck("six release", 1'b0, 60);

    $display("[TB] key 3 bounce while queue full");
    applyStimulus(MASK_E, 1'b0);
    stepCycle(30);
    checkOutput("full valid", 32'(ev_valid), 32'd1);
    checkOutput("full no overflow yet", 32'(ev_overflow), 32'd0);
    applyStimulus(MASK_E | 16'h0008, 1'b0);
    waitKeyBit(3, 1'b1, 40, atEdge);
    applyStimulus(MASK_E, 1'b0);
    waitKeyBit(3, 1'b0, 40, atEdge);
    stepCycle(1);
    checkOutput("bounce overflow", 32'(ev_overflow), 32'd1);
    expCodes = '{0, 4, 6, 7};
    drainAndCheck("bounce queue", 1'b1, 20);
    stepCycle(20);
    checkOutput("bounce cancelled", 32'(ev_valid), 32'd0);
    checkOutput("overflow sticky", 32'(ev_overflow), 32'd1);

    $display("[TB] reset with events queued");
    applyStimulus(MASK_F, 1'b0);
    stepCycle(30);
    checkOutput("pre-reset valid", 32'(ev_valid), 32'd1);
    checkOutput("pre-reset code", 32'(ev_code), 32'd8);
    #2 rst = 1'b0;
    #1;
    checkOutput("mid reset ev_valid", 32'(ev_valid), 32'd0);
    checkOutput("mid reset key_state", 32'(key_state), 32'd0);
    checkOutput("mid reset overflow", 32'(ev_overflow), 32'd0);
    checkOutput("mid reset ev_code", 32'(ev_code), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    edgeCnt = 0;
    waitKeyBit(0, 1'b1, 40, atEdge);
    checkOutput("post-reset accept edge", 32'(atEdge), 32'(expToggle(0)));
    checkOutput("post-reset key_state", 32'(key_state), 32'(MASK_F));
    expCodes = '{0, 4, 6, 7, 8, 11, 12};
    drainAndCheck("re-report", 1'b1, 40);
    checkOutput("re-report overflow", 32'(ev_overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end
endmodule
